// File: rtl/router_grant_arbiter_pkg.sv
// Package router_arb_pkg: shared types and constants for the router grant arbiter.
//   arb_state_t : per-port packet FSM state (IDLE = free, LOCKED = mid-packet)
//   PORT_*      : output merge index (P, C1, C2)
//   SEL_*       : grant token value (which merge input gets the flit)
package router_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

  localparam int   PORT_P  = 0;
  localparam int   PORT_C1 = 1;
  localparam int   PORT_C2 = 2;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/router_grant_arbiter_port.sv
// grant_rr_port: grant scheduler for one 2:1 output merge.
// Packet-level round-robin between In0/In1, a grant-token FIFO and an
// issued-grant counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req_valid[i] : merge input i has a flit routed here
//   req_tail[i]  : that flit ends its packet (qualified by req_valid[i])
//   req_ready[i] : request from input i accepted this cycle
//   grant_valid  : a token is waiting at the FIFO head
//   grant_sel    : head token value (0 = In0, 1 = In1)
//   grant_ready  : merge consumes the head token
//   grant_count  : tokens pushed since reset (wraps)
//   dbg_state    : current FSM state
// Handshake: a request or token moves on a cycle where valid and ready are
// both high at the clock edge; a requester holds valid/tail until ready, and
// dropping valid before ready has no effect.
module grant_rr_port
  import router_arb_pkg::*;
#(
  parameter int GQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_tail,
  output logic [1:0]       req_ready,
  output logic             grant_valid,
  output logic             grant_sel,
  input  logic             grant_ready,
  output logic [CNT_W-1:0] grant_count,
  output arb_state_t       dbg_state
);

  localparam int AW = $clog2(GQ_DEPTH);

  arb_state_t  state;
  logic        owner;
  logic        prio;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        mem [GQ_DEPTH];

  logic        full;
  logic        empty;
  logic        winner;
  logic        cand_valid;
  logic        accept;
  logic        pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Acceptance uses the registered full flag only, so a pop in the same
  // cycle never opens a path from grant_ready to req_ready.
  always_comb begin
    winner     = SEL_IN0;
    cand_valid = 1'b0;
    if (state == ARB_LOCKED) begin
      winner     = owner;
      cand_valid = req_valid[owner];
    end else begin
      cand_valid = |req_valid;
      if (req_valid == 2'b11) winner = prio;
      else                    winner = req_valid[1];
    end
    accept    = cand_valid && !full && !reset;
    req_ready = 2'b00;
    if (accept) req_ready[winner] = 1'b1;
  end

  assign pop = grant_ready && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      owner       <= SEL_IN0;
      prio        <= SEL_IN0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      grant_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr      <= wr_ptr + 1'b1;
        grant_count <= grant_count + 1'b1;
        // Priority moves only when a packet completes; the input that just
        // finished a packet drops to lowest priority.
        if (req_tail[winner]) begin
          state <= ARB_IDLE;
          prio  <= ~winner;
        end else begin
          state <= ARB_LOCKED;
          owner <= winner;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Token storage needs no reset: contents are only visible behind the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= winner;
  end

  assign grant_valid = !empty;
  assign grant_sel   = mem[rd_ptr[AW-1:0]];
  assign dbg_state   = state;

endmodule

// File: rtl/router_grant_arbiter.sv
// router_grant_arbiter: grant scheduler for the three 2:1 output merges of a
// router node. One independent grant_rr_port per merge.
// Port index: 0 = P out (In0=C1, In1=C2), 1 = C1 out (In0=C2, In1=P),
//             2 = C2 out (In0=C1, In1=P).
// Ports:
//   CLK, RESET      : clock, synchronous active-high reset
//   req_valid/tail  : [2p+i] request from input i of merge p, tail flag
//   req_ready       : [2p+i] request accepted this cycle
//   grant_valid/sel : [p] grant token available / token value
//   grant_ready     : [p] merge consumes the token
//   port_locked     : [p] merge is mid-packet
//   grant_count     : [p*CNT_W +: CNT_W] tokens pushed since reset
module router_grant_arbiter
  import router_arb_pkg::*;
#(
  parameter int NPORT    = 3,
  parameter int GQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NPORT*2-1:0]     req_valid,
  input  logic [NPORT*2-1:0]     req_tail,
  output logic [NPORT*2-1:0]     req_ready,
  output logic [NPORT-1:0]       grant_valid,
  output logic [NPORT-1:0]       grant_sel,
  input  logic [NPORT-1:0]       grant_ready,
  output logic [NPORT-1:0]       port_locked,
  output logic [NPORT*CNT_W-1:0] grant_count
);

  arb_state_t port_state [NPORT];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    grant_rr_port #(
      .GQ_DEPTH (GQ_DEPTH),
      .CNT_W    (CNT_W)
    ) u_port (
      .clk         (CLK),
      .reset       (RESET),
      .req_valid   (req_valid[2*p +: 2]),
      .req_tail    (req_tail[2*p +: 2]),
      .req_ready   (req_ready[2*p +: 2]),
      .grant_valid (grant_valid[p]),
      .grant_sel   (grant_sel[p]),
      .grant_ready (grant_ready[p]),
      .grant_count (grant_count[p*CNT_W +: CNT_W]),
      .dbg_state   (port_state[p])
    );

    assign port_locked[p] = (port_state[p] == ARB_LOCKED);
  end

endmodule
